// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding and
// default widths for the instruction-memory address and cycle counter.
package exec_ctrl_pkg;

   localparam int IMEM_AW_DEF = 10;
   localparam int CYC_W_DEF   = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/exec_ctrl_if.sv
// Program-load stream and instruction-memory write port between the host
// side (master) and the run-control sequencer (slave).
interface exec_ctrl_if
   import exec_ctrl_pkg::*;
#(
   parameter int IMEM_AW = IMEM_AW_DEF
);

   logic               load_valid;
   logic [31:0]        load_data;
   logic               load_last;
   logic               load_ready;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/exec_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// enable and the value sticks at all-ones instead of wrapping.
module sat_counter
   import exec_ctrl_pkg::*;
#(
   parameter int W = CYC_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/exec_ctrl.sv
// Run-control sequencer: streams a program into instruction memory, pulses a
// one-cycle core clear, then enables the core until HALT or the cycle limit.
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int IMEM_AW = IMEM_AW_DEF,
   parameter int CYC_W   = CYC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   exec_ctrl_if.slave       bus,
   input  logic             halt_in,
   input  logic [CYC_W-1:0] timeout_limit,
   output logic             cpu_clr,
   output logic             cpu_en,
   output logic             busy,
   output logic             finished,
   output logic             timed_out,
   output logic             load_err,
   output logic [CYC_W-1:0] cycle_count
);

   localparam logic [IMEM_AW-1:0] ADDR_MAX = '1;

   state_e             state_q;
   state_e             state_d;
   logic [IMEM_AW-1:0] addr_q;
   logic [IMEM_AW-1:0] addr_d;
   logic               timed_out_q;
   logic               timed_out_d;
   logic               load_err_q;
   logic               load_err_d;
   logic               cnt_clr;
   logic               accept;
   logic               limit_hit;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      timed_out_d = timed_out_q;
      load_err_d  = load_err_q;
      cnt_clr     = 1'b0;
      accept      = (state_q == ST_LOAD) && bus.load_valid;
      limit_hit   = (timeout_limit != '0) && (cycle_count == timeout_limit);
      // HALT must not commit, and the limit blocks the instruction beyond it.
      cpu_en      = (state_q == ST_RUN) && !halt_in && !limit_hit;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_LOAD;
               addr_d      = '0;
               timed_out_d = 1'b0;
               load_err_d  = 1'b0;
               cnt_clr     = 1'b1;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               addr_d = addr_q + IMEM_AW'(1);
               if (bus.load_last) begin
                  state_d = ST_CLEAR;
               end else if (addr_q == ADDR_MAX) begin
                  load_err_d = 1'b1;
                  state_d    = ST_CLEAR;
               end
            end
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_in) begin
               state_d = ST_DONE;
            end else if (limit_hit) begin
               state_d     = ST_DONE;
               timed_out_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_d     = ST_IDLE;
         addr_d      = '0;
         timed_out_d = 1'b0;
         load_err_d  = 1'b0;
         cnt_clr     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         timed_out_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         timed_out_q <= timed_out_d;
         load_err_q  <= load_err_d;
      end
   end

   sat_counter #(
      .W (CYC_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cpu_en),
      .count (cycle_count)
   );

   assign bus.load_ready = (state_q == ST_LOAD);
   assign bus.imem_we    = accept;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = bus.load_data;

   assign cpu_clr   = (state_q == ST_CLEAR);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_CLEAR) || (state_q == ST_RUN);
   assign finished  = (state_q == ST_DONE);
   assign timed_out = timed_out_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed and randomized programs, each predicted from
// the word count, HALT position, limit and abort point.
module tb_exec_ctrl;

   localparam int AW    = 2;
   localparam int CW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          halt_in = 1'b0;
   logic [CW-1:0] timeout_limit = '0;
   logic          cpu_clr;
   logic          cpu_en;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic          load_err;
   logic [CW-1:0] cycle_count;

   int checks = 0;
   int errors = 0;

   exec_ctrl_if #(.IMEM_AW(AW)) bus_if ();

   exec_ctrl #(
      .IMEM_AW (AW),
      .CYC_W   (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .bus           (bus_if),
      .halt_in       (halt_in),
      .timeout_limit (timeout_limit),
      .cpu_clr       (cpu_clr),
      .cpu_en        (cpu_en),
      .busy          (busy),
      .finished      (finished),
      .timed_out     (timed_out),
      .load_err      (load_err),
      .cycle_count   (cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus_if.load_ready), 32'(0));
      chk({tag, "_we"},    32'(bus_if.imem_we),    32'(0));
      chk({tag, "_addr"},  32'(bus_if.imem_addr),  32'(0));
      chk({tag, "_clr"},   32'(cpu_clr),           32'(0));
      chk({tag, "_en"},    32'(cpu_en),            32'(0));
      chk({tag, "_busy"},  32'(busy),              32'(0));
      chk({tag, "_fin"},   32'(finished),          32'(0));
      chk({tag, "_tout"},  32'(timed_out),         32'(0));
      chk({tag, "_lerr"},  32'(load_err),          32'(0));
      chk({tag, "_cnt"},   32'(cycle_count),       32'(0));
   endtask

   // n words offered, last_idx marks load_last (-1: never), HALT raised from
   // RUN cycle h on, limit lim (0: none), abort in RUN cycle ab (-1: never).
   task automatic run_prog(input int n, input int last_idx, input int h, input int lim, input int ab);
      int          stop;
      int          e;
      int          acc;
      int          gap;
      bit          err_exp;
      bit          tout_exp;
      bit          broke;
      bit          aborted;
      logic [31:0] word;

      err_exp  = !(last_idx >= 0 && last_idx < DEPTH);
      stop     = err_exp ? DEPTH : last_idx + 1;
      tout_exp = (lim != 0) && (lim < h);
      e        = tout_exp ? lim : h;
      acc      = 0;
      broke    = 1'b0;
      aborted  = 1'b0;

      @(posedge clk); #1;
      start = 1'b1;
      timeout_limit = CW'(lim);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("ld_ready", 32'(bus_if.load_ready), 32'(1));
      chk("ld_cnt0",  32'(cycle_count),       32'(0));
      chk("ld_tout0", 32'(timed_out),         32'(0));
      chk("ld_lerr0", 32'(load_err),          32'(0));
      chk("ld_fin0",  32'(finished),          32'(0));

      for (int i = 0; i < n; i++) begin
         if (i < stop) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
               @(posedge clk); #1;
               bus_if.load_valid = 1'b0;
               bus_if.load_last  = 1'b0;
               @(negedge clk);
               chk("gap_we", 32'(bus_if.imem_we), 32'(0));
            end
         end
         @(posedge clk); #1;
         word = $urandom;
         bus_if.load_valid = 1'b1;
         bus_if.load_data  = word;
         bus_if.load_last  = (i == last_idx);
         @(negedge clk);
         if (!bus_if.load_ready) begin
            chk("xtra_we", 32'(bus_if.imem_we), 32'(0));
            broke = 1'b1;
            break;
         end
         chk("wr_we",   32'(bus_if.imem_we),   32'(1));
         chk("wr_addr", 32'(bus_if.imem_addr), 32'(acc));
         chk("wr_data", bus_if.imem_wdata,     word);
         acc++;
      end

      if (!broke) begin
         @(posedge clk); #1;
      end
      bus_if.load_valid = 1'b0;
      bus_if.load_last  = 1'b0;
      if (!broke) @(negedge clk);

      chk("acc_words", 32'(acc),               32'(stop));
      chk("clr_pulse", 32'(cpu_clr),           32'(1));
      chk("clr_en",    32'(cpu_en),            32'(0));
      chk("clr_ready", 32'(bus_if.load_ready), 32'(0));
      chk("clr_lerr",  32'(load_err),          32'(err_exp));

      for (int c = 0; c <= e; c++) begin
         @(posedge clk); #1;
         halt_in = (c >= h);
         abort   = (c == ab);
         @(negedge clk);
         chk("run_en",   32'(cpu_en),      32'(c < e));
         chk("run_cnt",  32'(cycle_count), 32'(sat(c)));
         chk("run_busy", 32'(busy),        32'(1));
         chk("run_clr",  32'(cpu_clr),     32'(0));
         if (c == ab) begin
            aborted = 1'b1;
            break;
         end
      end

      @(posedge clk); #1;
      halt_in = 1'b0;
      abort   = 1'b0;
      @(negedge clk);
      if (aborted) begin
         chk_zero("abt");
      end else begin
         chk("done_fin",  32'(finished),    32'(1));
         chk("done_busy", 32'(busy),        32'(0));
         chk("done_cnt",  32'(cycle_count), 32'(sat(e)));
         chk("done_tout", 32'(timed_out),   32'(tout_exp));
         chk("done_lerr", 32'(load_err),    32'(err_exp));
         chk("done_en",   32'(cpu_en),      32'(0));
      end
      $display("prog n=%0d last=%0d halt=%0d limit=%0d abort=%0d writes=%0d commits=%0d timed_out=%0d load_err=%0d",
               n, last_idx, h, lim, ab, acc, aborted ? 0 : e, tout_exp, err_exp);
   endtask

   initial begin
      int last_idx;
      int stop;
      int n;
      int h;
      int lim;
      int ab;

      bus_if.load_valid = 1'b0;
      bus_if.load_data  = '0;
      bus_if.load_last  = 1'b0;

      #2;
      chk_zero("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("idle");

      run_prog(4, 3, 5, 0, -1);      // basic load and run
      run_prog(4, 3, 1000, 3, -1);   // timeout after 3 commits
      run_prog(2, 1, 4, 4, -1);      // halt and limit coincide
      run_prog(5, -1, 2, 0, -1);     // wrap without load_last
      run_prog(3, 2, 10, 0, 2);      // abort in RUN cycle 2
      run_prog(1, 0, 1, 0, -1);      // reload from address 0 after abort
      run_prog(4, 3, 20, 0, -1);     // count saturates with limit disabled

      for (int t = 0; t < 25; t++) begin
         last_idx = int'($urandom_range(0, 5)) - 1;
         stop     = (last_idx >= 0 && last_idx < DEPTH) ? last_idx + 1 : DEPTH;
         n        = stop + int'($urandom_range(0, 1));
         h        = int'($urandom_range(0, 20));
         lim      = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, CMAX));
         ab       = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         run_prog(n, last_idx, h, lim, ab);
      end

      // Asynchronous reset in the middle of a load.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         bus_if.load_valid = 1'b1;
         bus_if.load_data  = $urandom;
         bus_if.load_last  = 1'b0;
         @(negedge clk);
         chk("rl_we",   32'(bus_if.imem_we),   32'(1));
         chk("rl_addr", 32'(bus_if.imem_addr), 32'(i));
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("post_rst_we",    32'(bus_if.imem_we),    32'(0));
         chk("post_rst_ready", 32'(bus_if.load_ready), 32'(0));
      end
      bus_if.load_valid = 1'b0;
      $display("prog async reset during load, three words offered after release");

      run_prog(4, 3, 3, 0, -1);      // normal operation after reset

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
